alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the processor's combinational ALU, for the execute stage.
- Keeps the existing 3-bit cntrl encoding.
- Adds a logical-shift-left op and an iterative multi-cycle multiply.
- Adds a valid/ready input handshake and an ARM-style NZCV flag register with per-operation flag-set enable.

Parameters:
WIDTH, 64, datapath width in bits; legal values are powers of two, minimum 8.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operation request
in_ready  output  1  high when an operation can be accepted (state IDLE)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cntrl  input  3  operation select
set_flags  input  1  update NZCV when this operation completes
result  output  WIDTH  registered result of the last completed operation
out_valid  output  1  one-cycle pulse: result is new
busy  output  1  high while a multiply is in progress
negative  output  1  N flag, registered
zero  output  1  Z flag, registered
overflow  output  1  V flag, registered
carry_out  output  1  C flag, registered

Behaviour:
- Reset (reset_n low, takes effect immediately):
  - state=IDLE.
  - result, out_valid, busy and all four flags = 0.
  - Multiply datapath registers = 0.
  - in_valid is ignored while reset_n is low.
- Accept: in_valid && in_ready at a rising edge. A, B, cntrl and set_flags are captured on that edge.
- in_ready = (state==IDLE), combinational from the state register.
- Operations:
  - 000: B
  - 001: A << B[SHW-1:0], zero fill
  - 010: A+B
  - 011: A-B, computed as A+~B+1
  - 100: A&B
  - 101: A|B
  - 110: A^B
  - 111: low WIDTH bits of A*B, unsigned (result is identical for two's complement)
- Single-cycle ops (000-110): result and out_valid update on the accept edge; latency 1, throughput 1 per cycle. State stays IDLE.
- Multiply FSM, states IDLE and MUL:
  - On accept: mcand=A, mplier=B, acc=0, cnt=0; go to MUL; busy=1.
  - Each MUL cycle: if mplier[0] then acc=acc+mcand (mod 2^WIDTH); mcand<<=1; mplier>>=1; cnt++.
  - On the edge where cnt==WIDTH-1 completes its step: result=final acc, out_valid=1, busy=0, go to IDLE.
  - Fixed latency: out_valid rises on the WIDTH-th edge after the accept edge. No early termination.
- out_valid is high for exactly one cycle per accepted op. There is no output backpressure.
- result holds its value between completions.
- Flags update only on a completing op whose captured set_flags=1:
  - N=result[WIDTH-1]; Z=(result==0).
  - 010/011: C = carry out of the WIDTH-bit adder (subtract: C=1 means no borrow); V = signed overflow.
  - All other ops: C and V hold their previous values.
- Flags with set_flags=0 are all unchanged.
- Back-to-back: a new op can be accepted on the edge immediately after a single-cycle op, and on the edge after the multiply completion edge. in_ready is high again in the cycle after out_valid for a multiply.
- Reset during MUL: aborts the multiply; no out_valid is produced; flags clear.
- Shift amount 0 returns A. Bits of B above SHW are ignored for op 001.
- Codes are exhaustive; there is no illegal cntrl value.

Test Plan:
1. WIDTH=64, cntrl=010, A=0x7FFF_FFFF_FFFF_FFFF, B=1, set_flags=1 -> next edge: result=0x8000_0000_0000_0000, out_valid pulse, N=1 Z=0 C=0 V=1.
2. cntrl=011, A=5, B=5, set_flags=1, then cntrl=100, A=0xF0, B=0x0F, set_flags=1 back-to-back -> first: result=0, Z=1 C=1 V=0. Second: result=0, Z=1, N=0, C=1 and V=0 held.
3. WIDTH=8, cntrl=111, A=0x0D, B=0x0B, set_flags=1 -> in_ready low and busy high for 8 cycles; result=0x8F on the 8th edge with a single out_valid pulse; N=1 Z=0. An in_valid held high during MUL is not accepted until in_ready returns.
4. WIDTH=64, cntrl=001, A=1, B=0x1_003F -> result=0x8000_0000_0000_0000. Repeat with B=0 -> result=A.
5. Start a multiply (WIDTH=8, A=0xFF, B=0xFF), assert reset_n low on the 4th MUL cycle -> out_valid never pulses; result=0, flags=0, in_ready=1. A fresh multiply (A=0xFF, B=0xFF) then yields 0x01.
6. cntrl=010, A=0xFFFF_FFFF_FFFF_FFFF, B=1, set_flags=0, after flags were previously set to N=1 -> result=0, out_valid pulses, NZCV unchanged.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand handshake in, registered result and NZCV flags out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             set_flags;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             busy;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, A, B, cntrl, set_flags,
    input  in_ready, result, out_valid, busy, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, A, B, cntrl, set_flags,
    output in_ready, result, out_valid, busy, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle ops, shift-and-add multiply over WIDTH cycles,
// valid/ready input handshake and an NZCV flag register with per-op update enable.
module alu_seq #(
  parameter int unsigned WIDTH = 64
) (
  input logic       clk,
  input logic       reset_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned SW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [2:0]     OP_MUL   = 3'b111;

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [SHW-1:0]   cnt_q,       cnt_d;
  logic             mul_sf_q,    mul_sf_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   sum_c;
  logic             add_v_c;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] acc_step_c;

  // Shared adder: cntrl[0] selects subtract as A + ~B + 1.
  always_comb begin
    b_eff_c = bus.cntrl[0] ? ~bus.B : bus.B;
    sum_c   = SW'(bus.A) + SW'(b_eff_c) + SW'(bus.cntrl[0]);
    add_v_c = (bus.A[MSB] == b_eff_c[MSB]) && (sum_c[MSB] != bus.A[MSB]);
    case (bus.cntrl)
      3'b000:  alu_c = bus.B;
      3'b001:  alu_c = bus.A << bus.B[SHW-1:0];
      3'b010:  alu_c = sum_c[WIDTH-1:0];
      3'b011:  alu_c = sum_c[WIDTH-1:0];
      3'b100:  alu_c = bus.A & bus.B;
      3'b101:  alu_c = bus.A | bus.B;
      3'b110:  alu_c = bus.A ^ bus.B;
      default: alu_c = '0;
    endcase
    acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_sf_d    = mul_sf_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.cntrl == OP_MUL) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            mul_sf_d = bus.set_flags;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d    = alu_c;
            out_valid_d = 1'b1;
            if (bus.set_flags) begin
              n_d = alu_c[MSB];
              z_d = (alu_c == '0);
              if (bus.cntrl[2:1] == 2'b01) begin
                c_d = sum_c[WIDTH];
                v_d = add_v_c;
              end
            end
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // Fixed WIDTH steps; the last step's sum is the product.
        if (cnt_q == CNT_LAST) begin
          result_d    = acc_step_c;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
          if (mul_sf_q) begin
            n_d = acc_step_c[MSB];
            z_d = (acc_step_c == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_sf_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_sf_q    <= mul_sf_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.negative  = n_q;
  assign bus.zero      = z_q;
  assign bus.carry_out = c_q;
  assign bus.overflow  = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 64-bit and an 8-bit instance, directed vector table, multi-cycle
// corner sequences and random ops checked against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst64_n, rst8_n;

  alu_seq_if #(.WIDTH(64)) if64 ();
  alu_seq_if #(.WIDTH(8))  if8 ();

  alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset_n(rst64_n), .bus(if64.slave));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(rst8_n),  .bus(if8.slave));

  typedef struct {
    bit          sel;   // 0: 64-bit instance, 1: 8-bit instance
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    bit          sf;
    logic [63:0] res;
    logic [3:0]  f;     // {N,Z,C,V}
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [3:0] mf [2];

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endfunction

  function automatic logic signed [127:0] sx(input logic [63:0] x, input int w);
    logic signed [127:0] t;
    t = 128'(x);
    if (x[w-1]) t = t - (128'sd1 <<< w);
    return t;
  endfunction

  // Reference: plain arithmetic on the integer values of the operands.
  function automatic void model(input int w, input logic [2:0] op, input logic [63:0] a_in,
                                input logic [63:0] b_in, input logic [3:0] fin, input bit sf,
                                output logic [63:0] r, output logic [3:0] fout);
    logic [63:0] m, a, b;
    logic [127:0] wide;
    logic signed [127:0] s, lim;
    bit c, v, arith;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & m;
    b = b_in & m;
    c = fin[1];
    v = fin[0];
    arith = 0;
    s = '0;
    case (op)
      3'd0: r = b;
      3'd1: r = (a << (b % 64'(w))) & m;
      3'd2: begin wide = 128'(a) + 128'(b); r = wide[63:0] & m; c = wide[w]; s = sx(a, w) + sx(b, w); arith = 1; end
      3'd3: begin r = (a - b) & m; c = (a >= b); s = sx(a, w) - sx(b, w); arith = 1; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = (a * b) & m;
    endcase
    if (arith) begin
      lim = 128'sd1 <<< (w - 1);
      v = (s >= lim) || (s < -lim);
    end
    fout = sf ? {r[w-1], (r == 64'd0), c, v} : fin;
  endfunction

  function automatic logic [63:0] obs_res(input bit sel);
    return sel ? 64'(if8.result) : if64.result;
  endfunction
  function automatic logic [3:0] obs_f(input bit sel);
    return sel ? {if8.negative, if8.zero, if8.carry_out, if8.overflow}
               : {if64.negative, if64.zero, if64.carry_out, if64.overflow};
  endfunction
  function automatic logic obs_ov(input bit sel);
    return sel ? if8.out_valid : if64.out_valid;
  endfunction

  task automatic drive(input bit sel, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit sf);
    if (sel) begin
      if8.A = a[7:0]; if8.B = b[7:0]; if8.cntrl = op; if8.set_flags = sf;
      if8.in_valid = 1'b1; if64.in_valid = 1'b0;
    end else begin
      if64.A = a; if64.B = b; if64.cntrl = op; if64.set_flags = sf;
      if64.in_valid = 1'b1; if8.in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    if64.in_valid = 1'b0;
    if8.in_valid  = 1'b0;
  endtask

  // One accepted op; waits out a multiply with a bounded loop and checks its latency.
  task automatic do_op(input bit sel, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input bit sf, input logic [63:0] er, input logic [3:0] ef, input string tag);
    int w, cyc;
    w = sel ? 8 : 64;
    @(negedge clk);
    drive(sel, op, a, b, sf);
    @(posedge clk); #1;
    if (op == 3'b111) begin
      cyc = 0;
      @(negedge clk);
      if64.in_valid = 1'b0;
      if8.in_valid  = 1'b0;
      while (!obs_ov(sel) && cyc < w + 4) begin
        @(posedge clk); #1;
        cyc++;
      end
      check({tag, ".latency"}, 64'(cyc), 64'(w));
    end
    check({tag, ".out_valid"}, 64'(obs_ov(sel)), 64'd1);
    check({tag, ".result"}, obs_res(sel), er);
    check({tag, ".nzcv"}, 64'(obs_f(sel)), 64'(ef));
  endtask

  function automatic logic [63:0] pick();
    case ($urandom % 6)
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [63:0] er;
    logic [3:0] ef;
    int busy_cyc, rdy_low, pulses, first_pulse;

    tbl.push_back('{0, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'h8000_0000_0000_0000, 4'b1001});
    tbl.push_back('{0, 3'd3, 64'd5, 64'd5, 1, 64'd0, 4'b0110});
    tbl.push_back('{0, 3'd4, 64'hF0, 64'h0F, 1, 64'd0, 4'b0110});
    tbl.push_back('{0, 3'd1, 64'd1, 64'h1_003F, 0, 64'h8000_0000_0000_0000, 4'b0110});
    tbl.push_back('{0, 3'd1, 64'h1234, 64'd0, 0, 64'h1234, 4'b0110});
    tbl.push_back('{0, 3'd2, 64'h8000_0000_0000_0000, 64'd0, 1, 64'h8000_0000_0000_0000, 4'b1000});
    tbl.push_back('{0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 4'b1000});
    tbl.push_back('{0, 3'd3, 64'd0, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
    tbl.push_back('{0, 3'd3, 64'h8000_0000_0000_0000, 64'd1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011});
    tbl.push_back('{0, 3'd7, 64'd3, 64'd5, 1, 64'd15, 4'b0011});
    tbl.push_back('{0, 3'd0, 64'd7, 64'd0, 1, 64'd0, 4'b0111});
    tbl.push_back('{0, 3'd5, 64'hF0, 64'h0F, 1, 64'hFF, 4'b0011});
    tbl.push_back('{0, 3'd6, 64'hFF, 64'hFF, 1, 64'd0, 4'b0111});
    tbl.push_back('{1, 3'd7, 64'h0D, 64'h0B, 1, 64'h8F, 4'b1000});
    tbl.push_back('{1, 3'd2, 64'h7F, 64'h01, 1, 64'h80, 4'b1001});
    tbl.push_back('{1, 3'd3, 64'h00, 64'h01, 1, 64'hFF, 4'b1000});
    tbl.push_back('{1, 3'd1, 64'h01, 64'h0F, 1, 64'h80, 4'b1000});

    // Reset, with a request presented that must be ignored.
    rst64_n = 1'b0; rst8_n = 1'b0;
    if64.A = 64'd5; if64.B = 64'd5; if64.cntrl = 3'd2; if64.set_flags = 1'b1; if64.in_valid = 1'b1;
    if8.A = '0; if8.B = '0; if8.cntrl = '0; if8.set_flags = 1'b0; if8.in_valid = 1'b0;
    mf[0] = 4'b0; mf[1] = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d.result", s), obs_res(s[0]), 64'd0);
      check($sformatf("reset%0d.out_valid", s), 64'(obs_ov(s[0])), 64'd0);
      check($sformatf("reset%0d.nzcv", s), 64'(obs_f(s[0])), 64'd0);
    end
    check("reset.in_ready", 64'(if64.in_ready), 64'd1);
    check("reset.busy", 64'(if64.busy), 64'd0);
    @(negedge clk);
    if64.in_valid = 1'b0;
    rst64_n = 1'b1; rst8_n = 1'b1;

    // Directed vectors; single-cycle entries run back-to-back with in_valid held.
    foreach (tbl[i]) begin
      model(tbl[i].sel ? 8 : 64, tbl[i].op, tbl[i].a, tbl[i].b, mf[tbl[i].sel], tbl[i].sf, er, ef);
      mf[tbl[i].sel] = ef;
      do_op(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, tbl[i].res, tbl[i].f,
            $sformatf("vec%0d", i));
    end
    idle();
    @(posedge clk); #1;
    check("idle.out_valid64", 64'(if64.out_valid), 64'd0);
    check("idle.out_valid8", 64'(if8.out_valid), 64'd0);

    // 8-bit multiply with a request held during MUL.
    model(8, 3'd7, 64'h0D, 64'h0B, mf[1], 1, er, ef);
    mf[1] = ef;
    @(negedge clk);
    drive(1, 3'd7, 64'h0D, 64'h0B, 1);
    @(posedge clk); #1;
    busy_cyc = int'(if8.busy);
    rdy_low  = int'(!if8.in_ready);
    @(negedge clk);
    drive(1, 3'd2, 64'd1, 64'd1, 0);
    pulses = 0; first_pulse = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      busy_cyc += int'(if8.busy);
      rdy_low  += int'(!if8.in_ready);
      if (if8.out_valid) begin
        pulses++;
        if (first_pulse == 0) first_pulse = k;
      end
      if (k == 8) begin
        check("mulhold.result", 64'(if8.result), er);
        check("mulhold.nzcv", 64'(obs_f(1)), 64'(ef));
        check("mulhold.in_ready", 64'(if8.in_ready), 64'd1);
      end
      if (k == 9) check("mulhold.next_result", 64'(if8.result), 64'd2);
    end
    check("mulhold.busy_cycles", 64'(busy_cyc), 64'd8);
    check("mulhold.ready_low_cycles", 64'(rdy_low), 64'd8);
    check("mulhold.first_pulse", 64'(first_pulse), 64'd8);
    check("mulhold.pulses", 64'(pulses), 64'd2);
    idle();

    // Reset in the 4th MUL cycle aborts the multiply.
    @(negedge clk);
    drive(1, 3'd7, 64'hFF, 64'hFF, 1);
    @(posedge clk);
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst8_n = 1'b0;
    #1;
    check("abort.result", 64'(if8.result), 64'd0);
    check("abort.nzcv", 64'(obs_f(1)), 64'd0);
    check("abort.in_ready", 64'(if8.in_ready), 64'd1);
    check("abort.busy", 64'(if8.busy), 64'd0);
    mf[1] = 4'b0;
    @(negedge clk);
    rst8_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      pulses += int'(if8.out_valid);
    end
    check("abort.no_pulse", 64'(pulses), 64'd0);
    model(8, 3'd7, 64'hFF, 64'hFF, mf[1], 1, er, ef);
    mf[1] = ef;
    check("abort.model_product", er, 64'h01);
    do_op(1, 3'd7, 64'hFF, 64'hFF, 1, er, ef, "abort.fresh_mul");

    // Random ops on both widths against the reference model.
    for (int i = 0; i < 300; i++) begin
      bit sel;
      logic [2:0] op;
      logic [63:0] a, b;
      bit sf;
      sel = 1'($urandom % 2);
      op  = 3'($urandom % 8);
      if (!sel && op == 3'd7 && ($urandom % 2) == 0) op = 3'd2;
      a   = pick();
      b   = (op == 3'd1) ? {$urandom, $urandom} : pick();
      sf  = 1'($urandom % 2);
      if (($urandom % 6) == 0) begin
        idle();
        @(posedge clk); #1;
        check($sformatf("rnd%0d.gap", i), 64'(obs_ov(sel)), 64'd0);
      end
      model(sel ? 8 : 64, op, a, b, mf[sel], sf, er, ef);
      mf[sel] = ef;
      do_op(sel, op, a, b, sf, er, ef, $sformatf("rnd%0d", i));
    end
    idle();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
